// File: rtl/clk_pkg.sv
// Shared definitions for the clock divider controller.
//   DIV_W      width of the divide exponent
//   RESET_DIV  exponent the divider holds out of reset
//   state_e    sequencer state encoding
//   clamp_div  lifts an exponent up to a floor value
package clk_pkg;

    localparam int unsigned DIV_W     = 4;
    localparam int unsigned RESET_DIV = 2;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StWrite,
        StWait,
        StAck
    } state_e;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div,
                                                   input logic [DIV_W-1:0] min_div);
        return (div < min_div) ? min_div : div;
    endfunction

endpackage

// File: rtl/clock_div_ctrl_arb.sv
// Two-way round-robin arbiter.
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_req[1:0]      bit 0 = CSR, bit 1 = PM
//   i_advance       a grant is being taken this cycle; pointer moves
//   o_grant[1:0]    one-hot grant, zero when no request
module clock_div_ctrl_arb (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // High when PM wins a tie; PM is favoured out of reset.
    logic prio_pm_q, prio_pm_d;

    always_comb begin
        o_grant = 2'b00;
        unique case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = prio_pm_q ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    always_comb begin
        prio_pm_d = prio_pm_q;
        if (i_advance && (o_grant != 2'b00)) begin
            // Whoever just won loses the next tie.
            prio_pm_d = o_grant[0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio_pm_q <= 1'b1;
        end else begin
            prio_pm_q <= prio_pm_d;
        end
    end

endmodule

// File: rtl/clock_div_ctrl.sv
// Sequencer and arbiter in front of the programmable clock divider.
// Arbitrates CSR and power-manager exponent requests, writes the divider,
// waits for two toggles of the divided clock to confirm the change and then
// acknowledges the winner. The divider must share i_rst_n so both sides start
// at RESET_DIV.
//   i_clk, i_rst_n          clock and asynchronous active-low reset
//   i_csr_req/div, o_csr_ack  CSR request handshake
//   i_pm_req/div,  o_pm_ack   power-manager request handshake
//   o_div, o_div_we         divider write port (single-cycle strobe)
//   i_div_clk               divided clock, already in the i_clk domain
//   o_cur_div               exponent currently applied
//   o_busy                  sequencer not idle
//   o_tmo_err, i_tmo_clr    sticky apply-timeout flag and its clear
module clock_div_ctrl
    import clk_pkg::*;
#(
    parameter int unsigned MIN_DIV = 0,
    parameter int unsigned TMO_W   = 17,
    parameter int unsigned TMO_CYC = 70000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_csr_req,
    input  logic [DIV_W-1:0] i_csr_div,
    output logic             o_csr_ack,
    input  logic             i_pm_req,
    input  logic [DIV_W-1:0] i_pm_div,
    output logic             o_pm_ack,
    output logic [DIV_W-1:0] o_div,
    output logic             o_div_we,
    input  logic             i_div_clk,
    output logic [DIV_W-1:0] o_cur_div,
    output logic             o_busy,
    output logic             o_tmo_err,
    input  logic             i_tmo_clr
);

    localparam logic [DIV_W-1:0] MinDiv  = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] RstDiv  = DIV_W'(RESET_DIV);
    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TMO_CYC - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] tgt_q, tgt_d;
    logic             win_pm_q, win_pm_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             div_we_q, div_we_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic             csr_ack_q, csr_ack_d;
    logic             pm_ack_q, pm_ack_d;
    logic             tmo_err_q, tmo_err_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0]       tog_cnt_q, tog_cnt_d;
    logic             div_clk_prev_q;

    logic       toggle;
    logic       tmo_set;
    logic       enter_ack;
    logic       arb_advance;
    logic [1:0] arb_req;
    logic [1:0] arb_grant;

    assign toggle      = i_div_clk ^ div_clk_prev_q;
    assign arb_req     = {i_pm_req, i_csr_req};
    assign arb_advance = (state_q == StIdle) && (arb_req != 2'b00);

    clock_div_ctrl_arb u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (arb_req),
        .i_advance (arb_advance),
        .o_grant   (arb_grant)
    );

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        win_pm_d  = win_pm_q;
        div_d     = div_q;
        div_we_d  = 1'b0;
        cur_div_d = cur_div_q;
        tmo_cnt_d = tmo_cnt_q;
        tog_cnt_d = tog_cnt_q;
        tmo_set   = 1'b0;
        enter_ack = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_advance) begin
                    win_pm_d = arb_grant[1];
                    tgt_d    = arb_grant[1] ? clamp_div(i_pm_div, MinDiv)
                                            : clamp_div(i_csr_div, MinDiv);
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (tgt_q == cur_div_q) begin
                    state_d   = StAck;
                    enter_ack = 1'b1;
                end else begin
                    // Registered write port: value and strobe appear during WRITE.
                    div_d    = tgt_q;
                    div_we_d = 1'b1;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                tog_cnt_d = 2'd0;
                tmo_cnt_d = '0;
                state_d   = StWait;
            end
            StWait: begin
                if (tog_cnt_q == 2'd2) begin
                    cur_div_d = tgt_q;
                    state_d   = StAck;
                    enter_ack = 1'b1;
                end else if (tmo_cnt_q == TmoLast) begin
                    tmo_set   = 1'b1;
                    state_d   = StAck;
                    enter_ack = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (toggle) begin
                        tog_cnt_d = tog_cnt_q + 2'd1;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        csr_ack_d = enter_ack && !win_pm_q;
        pm_ack_d  = enter_ack && win_pm_q;

        // A timeout in the same cycle beats a clear.
        if (tmo_set) begin
            tmo_err_d = 1'b1;
        end else if (i_tmo_clr) begin
            tmo_err_d = 1'b0;
        end else begin
            tmo_err_d = tmo_err_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= StIdle;
            tgt_q          <= RstDiv;
            win_pm_q       <= 1'b0;
            div_q          <= RstDiv;
            div_we_q       <= 1'b0;
            cur_div_q      <= RstDiv;
            csr_ack_q      <= 1'b0;
            pm_ack_q       <= 1'b0;
            tmo_err_q      <= 1'b0;
            tmo_cnt_q      <= '0;
            tog_cnt_q      <= 2'd0;
            div_clk_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tgt_q          <= tgt_d;
            win_pm_q       <= win_pm_d;
            div_q          <= div_d;
            div_we_q       <= div_we_d;
            cur_div_q      <= cur_div_d;
            csr_ack_q      <= csr_ack_d;
            pm_ack_q       <= pm_ack_d;
            tmo_err_q      <= tmo_err_d;
            tmo_cnt_q      <= tmo_cnt_d;
            tog_cnt_q      <= tog_cnt_d;
            div_clk_prev_q <= i_div_clk;
        end
    end

    assign o_div     = div_q;
    assign o_div_we  = div_we_q;
    assign o_cur_div = cur_div_q;
    assign o_csr_ack = csr_ack_q;
    assign o_pm_ack  = pm_ack_q;
    assign o_tmo_err = tmo_err_q;
    assign o_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Self-checking bench for clock_div_ctrl: table of request vectors plus
// hand-written sequences for no-change latency, timeout and reset mid-WAIT.
module tb_clock_div_ctrl;
    import clk_pkg::*;

    localparam int unsigned TmoCyc = 1000;

    logic             clk;
    logic             rst_n;
    logic             csr_req, pm_req, tmo_clr;
    logic [DIV_W-1:0] csr_div, pm_div;
    logic             csr_ack, pm_ack, div_we, busy, tmo_err;
    logic [DIV_W-1:0] div, cur_div;
    logic             div_clk;
    logic             div_run;
    int               div_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    clock_div_ctrl #(
        .MIN_DIV (1),
        .TMO_W   (17),
        .TMO_CYC (TmoCyc)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_csr_req (csr_req),
        .i_csr_div (csr_div),
        .o_csr_ack (csr_ack),
        .i_pm_req  (pm_req),
        .i_pm_div  (pm_div),
        .o_pm_ack  (pm_ack),
        .o_div     (div),
        .o_div_we  (div_we),
        .i_div_clk (div_clk),
        .o_cur_div (cur_div),
        .o_busy    (busy),
        .o_tmo_err (tmo_err),
        .i_tmo_clr (tmo_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: divided clock toggles every 3 cycles while running,
    // reset together with the controller.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 0;
            div_clk <= 1'b0;
        end else if (div_run) begin
            if (div_cnt == 2) begin
                div_cnt <= 0;
                div_clk <= ~div_clk;
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic             csr_req;
        logic [DIV_W-1:0] csr_div;
        logic             pm_req;
        logic [DIV_W-1:0] pm_div;
        int               exp_first_pm;
        int               exp_we;
        int               exp_first_div;
        int               exp_last_div;
        int               exp_cur;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int  we_cnt;
        int  first_div;
        int  last_div;
        int  first_pm;
        int  cyc;
        bit  csr_pend;
        bit  pm_pend;
        we_cnt    = 0;
        first_div = -1;
        last_div  = -1;
        first_pm  = -1;
        cyc       = 0;
        csr_pend  = v.csr_req;
        pm_pend   = v.pm_req;
        csr_req   = v.csr_req;
        csr_div   = v.csr_div;
        pm_req    = v.pm_req;
        pm_div    = v.pm_div;
        while ((csr_pend || pm_pend) && cyc < 200) begin
            tick();
            cyc++;
            if (div_we) begin
                if (we_cnt == 0) first_div = int'(div);
                last_div = int'(div);
                we_cnt++;
            end
            if (csr_ack) begin
                if (first_pm < 0) first_pm = 0;
                csr_pend = 1'b0;
                csr_req  = 1'b0;
            end
            if (pm_ack) begin
                if (first_pm < 0) first_pm = 1;
                pm_pend = 1'b0;
                pm_req  = 1'b0;
            end
        end
        check($sformatf("vec%0d_done", idx), int'(cyc < 200), 1);
        check($sformatf("vec%0d_first_pm", idx), first_pm, v.exp_first_pm);
        check($sformatf("vec%0d_we_cnt", idx), we_cnt, v.exp_we);
        if (v.exp_we > 0) begin
            check($sformatf("vec%0d_first_div", idx), first_div, v.exp_first_div);
            check($sformatf("vec%0d_last_div", idx), last_div, v.exp_last_div);
        end
        check($sformatf("vec%0d_cur_div", idx), int'(cur_div), v.exp_cur);
        tick();
        check($sformatf("vec%0d_idle", idx), int'(busy), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int we_cyc;
        int ack_cyc;
        int cyc;
        bit saw_ack;

        //           csr  div    pm   div    1stPM we 1st last cur
        vecs[0] = '{1'b1, 4'd5, 1'b0, 4'd0, 0, 1, 5, 5, 5};  // plain change
        vecs[1] = '{1'b0, 4'd0, 1'b1, 4'd5, 1, 0, 0, 0, 5};  // no change
        vecs[2] = '{1'b1, 4'd0, 1'b0, 4'd0, 0, 1, 1, 1, 1};  // clamp to MIN_DIV=1
        vecs[3] = '{1'b1, 4'd3, 1'b1, 4'd7, 1, 2, 7, 3, 3};  // tie, PM favoured
        vecs[4] = '{1'b0, 4'd0, 1'b1, 4'd3, 1, 0, 0, 0, 3};  // PM alone, no change
        vecs[5] = '{1'b1, 4'd6, 1'b1, 4'd4, 0, 2, 6, 4, 4};  // tie, CSR favoured

        rst_n   = 1'b0;
        csr_req = 1'b0;
        pm_req  = 1'b0;
        csr_div = '0;
        pm_div  = '0;
        tmo_clr = 1'b0;
        div_run = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();

        check("rst_cur_div", int'(cur_div), 2);
        check("rst_div", int'(div), 2);
        check("rst_busy", int'(busy), 0);
        check("rst_div_we", int'(div_we), 0);
        check("rst_tmo_err", int'(tmo_err), 0);
        check("rst_acks", int'({csr_ack, pm_ack}), 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // No-change exact latency: cur_div is 4, PM asks for 4.
        pm_req = 1'b1;
        pm_div = 4'd4;
        tick();
        check("nc_busy", int'(busy), 1);
        check("nc_ack_early", int'(pm_ack), 0);
        tick();
        check("nc_ack", int'(pm_ack), 1);
        check("nc_no_we", int'(div_we), 0);
        pm_req = 1'b0;
        tick();
        check("nc_ack_pulse", int'(pm_ack), 0);
        check("nc_idle", int'(busy), 0);
        check("nc_cur", int'(cur_div), 4);

        // Timeout: freeze the divided clock, CSR asks for 9.
        div_run = 1'b0;
        repeat (3) tick();
        csr_req = 1'b1;
        csr_div = 4'd9;
        we_cyc  = -1;
        ack_cyc = -1;
        cyc     = 0;
        while (ack_cyc < 0 && cyc < TmoCyc + 50) begin
            tick();
            cyc++;
            if (div_we) we_cyc = cyc;
            if (csr_ack) begin
                ack_cyc = cyc;
                csr_req = 1'b0;
                check("tmo_err_set", int'(tmo_err), 1);
            end
        end
        check("tmo_acked", int'(ack_cyc >= 0), 1);
        check("tmo_latency", ack_cyc - we_cyc, TmoCyc + 1);
        check("tmo_cur_kept", int'(cur_div), 4);
        check("tmo_div_written", int'(div), 9);
        tick();
        check("tmo_err_sticky", int'(tmo_err), 1);
        tmo_clr = 1'b1;
        tick();
        tmo_clr = 1'b0;
        check("tmo_err_clr", int'(tmo_err), 0);

        // Reset during WAIT aborts without an ack.
        div_run = 1'b1;
        csr_req = 1'b1;
        csr_div = 4'd6;
        cyc     = 0;
        while (!div_we && cyc < 20) begin
            tick();
            cyc++;
        end
        check("mid_we_seen", int'(div_we), 1);
        tick();
        check("mid_in_wait", int'(busy), 1);
        rst_n   = 1'b0;
        csr_req = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cur", int'(cur_div), 2);
        check("mid_rst_ack", int'(csr_ack), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        saw_ack = 1'b0;
        repeat (10) begin
            tick();
            if (csr_ack || pm_ack) saw_ack = 1'b1;
        end
        check("mid_no_ack", int'(saw_ack), 0);
        check("mid_idle", int'(busy), 0);
        check("mid_cur_after", int'(cur_div), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
